// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx: MSB-first byte serialiser with COM alignment preamble and IDLE fill
module paralelo_serial_tx #(
  parameter int          DATA_W     = 8,
  parameter logic [7:0]  COM        = 8'hBC,
  parameter logic [7:0]  IDLE       = 8'h7C,
  parameter int          SYNC_WORDS = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              data_out,
  output logic              sym_start,
  output logic              active,
  output logic              load_ack
);
  localparam logic [0:0] ST_SYNC   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [3:0]        sync_cnt_q, sync_cnt_d;
  logic [0:0]        state_q, state_d;
  logic              data_out_q, data_out_d;
  logic              sym_start_q, sym_start_d;
  logic              load_ack_q, load_ack_d;
  logic              load, go;
  logic [2:0]        idx;
  logic [DATA_W-1:0] sym;
  // next-state: a load edge picks the next symbol, other edges shift out the held one
  always_comb begin
    load        = bit_cnt_q == 3'd7;
    go          = state_q == ST_ACTIVE || sync_cnt_q == 4'(SYNC_WORDS);
    sym         = !go ? COM : valid_in ? data_in : IDLE;
    idx         = 3'(DATA_W - 2) - bit_cnt_q;
    bit_cnt_d   = load ? 3'd0 : bit_cnt_q + 3'd1;
    shreg_d     = load ? sym : shreg_q;
    data_out_d  = load ? sym[DATA_W-1] : shreg_q[idx];
    sym_start_d = load;
    sync_cnt_d  = load && !go ? sync_cnt_q + 4'd1 : sync_cnt_q;
    state_d     = load && go ? ST_ACTIVE : state_q;
    load_ack_d  = load && go && valid_in;
  end
  // registers with synchronous reset; bit_cnt starts at 7 so the first edge loads
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      bit_cnt_q   <= 3'd7;
      shreg_q     <= '0;
      sync_cnt_q  <= 4'd0;
      state_q     <= ST_SYNC;
      data_out_q  <= 1'b0;
      sym_start_q <= 1'b0;
      load_ack_q  <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      sync_cnt_q  <= sync_cnt_d;
      state_q     <= state_d;
      data_out_q  <= data_out_d;
      sym_start_q <= sym_start_d;
      load_ack_q  <= load_ack_d;
    end
  end
  assign data_out  = data_out_q;
  assign sym_start = sym_start_q;
  assign active    = state_q == ST_ACTIVE;
  assign load_ack  = load_ack_q;
endmodule

// File: tb/tb_paralelo_serial_tx.sv
// tb_paralelo_serial_tx: symbol-level reference model feeding a per-cycle scoreboard
module tb_paralelo_serial_tx;
  localparam int SW = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic valid_in = 1'b0;
  logic data_out, sym_start, active, load_ack;
  logic [3:0] q[$];
  logic [3:0] exp_v, got_v;
  int compared = 0;
  int mismatched = 0;
  int k = 0;
  int w = 0;
  paralelo_serial_tx dut (
    .clk_32f(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .data_out(data_out), .sym_start(sym_start), .active(active), .load_ack(load_ack)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #2;
    if (q.size() != 0) begin
      exp_v = q.pop_front();
      got_v = {data_out, sym_start, active, load_ack};
      compared++;
      if (got_v !== exp_v) begin
        mismatched++;
        $display("FAIL cycle_out t=%0t: got dout,sym,act,ack=%b required %b", $time, got_v, exp_v);
      end
    end
  end
  task automatic send(input logic v, input logic [7:0] d);
    logic [7:0] s;
    logic a;
    valid_in = v;
    data_in  = d;
    a = k >= SW;
    s = !a ? 8'hBC : v ? d : 8'h7C;
    for (int i = 0; i < 8; i++) q.push_back({s[7-i], i == 0, a, i == 0 && a && v});
    k++;
  endtask
  task automatic sym(input logic v, input logic [7:0] d);
    send(v, d);
    repeat (8) @(negedge clk);
  endtask
  task automatic do_reset(input int n);
    reset = 1'b1;
    q.delete();
    k = 0;
    for (int i = 0; i < n; i++) begin
      q.push_back(4'b0000);
      @(negedge clk);
    end
    compared++;
    if ({data_out, sym_start, active, load_ack} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_state t=%0t: got dout,sym,act,ack=%b required 0000", $time,
               {data_out, sym_start, active, load_ack});
    end
    reset = 1'b0;
  endtask
  initial begin
    @(negedge clk);
    do_reset(3);
    sym(1'b1, 8'hFF);
    for (int i = 0; i < 5; i++) sym(1'b0, 8'h00);
    sym(1'b1, 8'hA5);
    sym(1'b1, 8'h01);
    sym(1'b0, 8'h55);
    sym(1'b1, 8'h80);
    sym(1'b1, 8'hBC);
    sym(1'b1, 8'h7C);
    for (int i = 0; i < 20; i++) sym(1'($urandom_range(0, 1)), 8'($urandom));
    send(1'b1, 8'h3C);
    repeat (4) @(negedge clk);
    do_reset(1);
    for (int i = 0; i < 6; i++) sym(1'($urandom_range(0, 1)), 8'($urandom));
    for (int i = 0; i < 40; i++) sym(1'($urandom_range(0, 1)), 8'($urandom));
    do_reset(2);
    for (int i = 0; i < 8; i++) sym(1'b1, 8'($urandom));
    while (q.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain_timeout t=%0t: %0d expectations still pending", $time, q.size());
    end
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
